// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO: operating mode enum, width helpers
// and default thresholds also used by the bench environment and scoreboard.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned DefaultWidth    = 8;
  localparam int unsigned DefaultDepth    = 16;
  localparam int unsigned DefaultAeThresh = 2;

  // Pointer width; a depth of 1 still needs a 1-bit address.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width; one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic int unsigned default_af(input int unsigned depth);
    return depth - 2;
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// Handshake/status bundle between producer/consumer logic and param_fifo.
//   master: drives write_en, data_in, read_en, flush, err_clr; observes data/status
//   slave : the FIFO itself
interface param_fifo_if import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefaultWidth,
  parameter int unsigned DEPTH      = DefaultDepth
) ();

  localparam int unsigned CW = cnt_w(DEPTH);

  logic                  write_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic                  flush;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_outp;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_en, data_in, read_en, flush, err_clr,
    input  data_outp, fifo_full, fifo_empty, almost_full, almost_empty, fill_count,
           overflow, underflow
  );

  modport slave (
    input  write_en, data_in, read_en, flush, err_clr,
    output data_outp, fifo_full, fifo_empty, almost_full, almost_empty, fill_count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous read port.
//   clock   : write clock
//   wr_en   : write strobe
//   wr_addr : write address, wr_data : write data
//   rd_addr : read address,  rd_data : combinational read data
// Contents are intentionally not reset.
module fifo_mem import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefaultWidth,
  parameter int unsigned DEPTH      = DefaultDepth
) (
  input  logic                      clock,
  input  logic                      wr_en,
  input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with optional first-word-fall-through output,
// almost-full/almost-empty flags, occupancy count, synchronous flush and sticky
// overflow/underflow flags.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : param_fifo_if slave modport (push/pop/flush/err_clr in; data and status out)
module param_fifo import fifo_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DefaultWidth,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned AF_THRESH  = default_af(DEPTH),
  parameter int unsigned AE_THRESH  = DefaultAeThresh,
  parameter int unsigned FWFT       = 0
) (
  input logic         clock,
  input logic         reset,
  param_fifo_if.slave bus
);

  localparam int unsigned AW   = ptr_w(DEPTH);
  localparam int unsigned CW   = cnt_w(DEPTH);
  localparam fifo_mode_e  Mode = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "param_fifo: DEPTH must be a power of two >= 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $fatal(1, "param_fifo: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "param_fifo: AE_THRESH must be in 0..DEPTH-1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $fatal(1, "param_fifo: DATA_WIDTH must be >= 1");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    // Flush discards both requests, so neither can be accepted nor flag an error.
    wr_ok    = bus.write_en & ~full_q  & ~bus.flush;
    rd_ok    = bus.read_en  & ~empty_q & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_ok && !rd_ok) begin
        count_d = count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_d = count_q - 1'b1;
      end
    end

    // Clear first so a same-cycle new error wins.
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.write_en && full_q && !bus.flush) ovf_d = 1'b1;
    if (bus.read_en && empty_q && !bus.flush) udf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Flags come from the next-state count so they move on the same edge as fill_count.
      full_q   <= (count_d == DepthC);
      empty_q  <= (count_d == '0);
      afull_q  <= (count_d >= AfC);
      aempty_q <= (count_d <= AeC);
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clock  (clock),
    .wr_en  (wr_ok),
    .wr_addr(wr_ptr_q),
    .wr_data(bus.data_in),
    .rd_addr(rd_ptr_q),
    .rd_data(mem_rdata)
  );

  if (Mode == FIFO_FWFT) begin : g_fwft
    // Head word is presented directly; forced to zero while empty so reset value is defined.
    assign bus.data_outp = empty_q ? '0 : mem_rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= mem_rdata;
      end
    end
    assign bus.data_outp = dout_q;
  end

  assign bus.fifo_full    = full_q;
  assign bus.fifo_empty   = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.fill_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: doc/param_fifo.md
Name: param_fifo

Overview:
Parametrised synchronous FIFO. It is the next generation of the team's single-clock `fifo` block, with generic width and depth.
It adds a first-word-fall-through mode, programmable almost-full/almost-empty flags, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.
It sits between producer and consumer logic in the same clock domain and is driven by the existing FIFO interface/driver/monitor bench flow.

Parameters:
DATA_WIDTH, 8, width of data_in/data_outp in bits (≥1)
DEPTH, 16, number of entries; power of two, ≥2
AF_THRESH, DEPTH-2, almost_full asserted when count ≥ AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count ≤ AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard (registered read, 1-cycle latency); 1 = first-word-fall-through

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
write_en  in  1  push request
data_in  in  DATA_WIDTH  push data
read_en  in  1  pop request
flush  in  1  synchronous clear of contents
err_clr  in  1  clears sticky error flags
data_outp  out  DATA_WIDTH  read data
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count ≥ AF_THRESH
almost_empty  out  1  count ≤ AE_THRESH
fill_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write_en seen while full
underflow  out  1  sticky: read_en seen while empty

Behaviour:
- Reset (reset=0, async assert, sync release):
  - pointers = 0, fill_count = 0, fifo_empty = 1, fifo_full = 0, almost_empty = 1.
  - almost_full = 0; overflow = 0; underflow = 0; data_outp = 0.
  - Memory contents are not reset.
- Accept rules, evaluated on the pre-edge state:
  - wr_ok = write_en & !fifo_full; rd_ok = read_en & !fifo_empty.
  - When full, a write is rejected even if a read happens in the same cycle.
  - When empty, a read is rejected even if a write happens in the same cycle.
- Pointers:
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - fill_count: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Flags: all flags are registered and derived from the next-state count, so they change on the same edge as fill_count with no extra lag.
- Standard mode (FWFT=0):
  - On rd_ok, data_outp <= mem[rd_ptr], valid the cycle after read_en.
  - Otherwise data_outp holds its last value, including on a rejected read.
- FWFT mode (FWFT=1):
  - data_outp = mem[rd_ptr] whenever fifo_empty = 0. The first written word appears the cycle after its write edge.
  - read_en acknowledges/pops the head word.
  - data_outp is don't-care while empty; the bench must not check it then.
- Overflow/underflow:
  - overflow <= 1 on write_en & fifo_full; underflow <= 1 on read_en & fifo_empty.
  - err_clr clears both; if err_clr and a new error occur in the same cycle, set wins.
- Flush:
  - Priority over read and write in that cycle: pointers and count go to 0, flags go to the empty state.
  - Same-cycle write/read are discarded and raise no error.
  - data_outp holds in standard mode; sticky flags are unaffected.
- Reset mid-operation: all contents are logically discarded immediately; outputs take reset values asynchronously.
- Parameter checks at elaboration:
  - DEPTH must be a power of two; AF_THRESH and AE_THRESH must be in range.
  - Violation → $fatal.

Decomposition:
- Package fifo_pkg:
  - fifo_mode_e (FIFO_STD, FIFO_FWFT);
  - localparam helper functions for pointer and count widths;
  - default threshold constants shared with the bench environment/scoreboard.
- Sub-module fifo_mem:
  - simple dual-port register array: write port on clock, asynchronous read address;
  - instantiated once; the control logic stays in param_fifo.

Test Plan:
- DEPTH=4, FWFT=0, after reset:
  - write 0x11, 0x22, 0x33, 0x44 → fill_count 1..4; fifo_full=1 after the 4th edge; almost_full=1 at count 2 (AF_THRESH=2).
  - 5th write → overflow=1 and contents unchanged.
  - 4 reads → data_outp 0x11..0x44, each 1 cycle after read_en; fifo_empty=1 at end.
- Empty FIFO: read_en and write_en(0xA5) in the same cycle → underflow=1, fill_count=1; next read returns 0xA5.
- FWFT=1:
  - write 0x5A → data_outp=0x5A the next cycle with no read_en.
  - read_en → fifo_empty=1; a following write of 0x6B is visible the cycle after it.
- Full FIFO with simultaneous read+write → read is accepted, write is rejected, overflow=1, fill_count=3.
- Same FIFO with count=2:
  - read+write together → count stays 2; order is preserved across pointer wrap (20 random-length bursts checked by the scoreboard).
- Count=3, flush together with write_en → count=0, fifo_empty=1, no error.
- Reset driven low mid-burst → all outputs at reset values before the next clock edge.
- err_clr → overflow/underflow return to 0.
